forward_tracker: RTL and testbench
==================================

# forward_tracker

Parametrised forwarding and load-use hazard unit for the pipelined CPU. It sits beside the decode/register-read stage. Internally it tracks in-flight register writers across DEPTH downstream stages in a shift register. For each of NUM_SRC source operands it produces a forward select and a stall request. It also keeps saturating stall and forward performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5: register address width.
- ZERO_REG, 31: hard-wired zero register; it is never forwarded and never causes a stall.
- NUM_SRC, 2: number of source operands checked per cycle.
- DEPTH, 2: number of tracked stages. Entry 0 is EX, entry DEPTH-1 is the last stage before writeback.
- LOAD_LAT, 1: load data is forwardable only from entry index ≥ LOAD_LAT.
- SEL_W, $clog2(DEPTH+1): forward select width.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: synchronous, active-low reset.
- issue_valid, input, 1: the decode-stage instruction is valid.
- issue_regwrite, input, 1: the decode instruction writes issue_rd.
- issue_is_load, input, 1: the decode instruction is a load.
- issue_rd, input, REG_ADDR_W: destination register of the decode instruction.
- src_regs, input, NUM_SRC*REG_ADDR_W: source registers. Operand i is bits [i*REG_ADDR_W +: REG_ADDR_W].
- flush, input, 1: squash entry 0 and the current issue.
- cnt_clear, input, 1: clear both performance counters.
- forward_sel, output, NUM_SRC*SEL_W: per operand. 0 means no forward; k means forward from entry k-1.
- stall, output, 1: hold decode and insert a bubble into entry 0.
- stall_count, output, 16: saturating count of stall cycles.
- fwd_count, output, 16: saturating count of cycles with at least one nonzero forward_sel.

## Operation
Each entry holds {valid, regwrite, is_load, rd}.

Match rule: operand i matches entry k when all of the following hold:
- entry k is valid and has regwrite set;
- entry k's rd equals src i;
- src i is not ZERO_REG.

Forward select:
- The youngest matching entry (lowest k) wins, giving forward_sel[i] = k+1.
- With no match, forward_sel[i] = 0.

Load-use:
- If the winning entry has is_load set and k < LOAD_LAT, operand i is "not ready".
- A not-ready operand forces forward_sel[i] = 0. An older match is not used instead.
- stall = issue_valid AND (any operand not ready). stall is gated by issue_valid.

Shift on every clock edge, with no global hold:
- entry[k] ← entry[k-1] for k = 1..DEPTH-1.
- entry[0] ← issue fields when issue_valid and !stall and !flush; otherwise entry[0] becomes a bubble (valid=0).

Flush:
- Invalidates what would shift out of entry 0, so the entry 1 written this edge is a bubble.
- Suppresses the issue.
- Older entries shift normally.

Counters:
- stall_count increments when stall=1. fwd_count increments when any forward_sel ≠ 0 and stall=0.
- Both saturate at 16'hFFFF.
- cnt_clear takes priority over an increment in the same cycle.

Reset (reset_n=0 at a clock edge):
- All entries become invalid and both counters become 0.
- Consequently forward_sel=0 and stall=0 from the cycle after reset.
- Reset mid-stall drops the tracked load; the stall is not retained.

## Timing
- forward_sel and stall are combinational from src_regs, issue_valid, issue_* and the registered entries, all in the same cycle. There is no registered output latency.
- Entries and counters update on the rising edge of clk only.
- A stalled instruction re-presents next cycle. After LOAD_LAT stall cycles the load reaches entry LOAD_LAT and stall deasserts with a nonzero forward_sel.
- Back-to-back writers to the same rd: the younger one shadows the older one.
- flush together with a would-be stall: the issue is dropped, stall still reflects the combinational condition, and stall_count counts it.

## Test plan
All scenarios use defaults (DEPTH=2, LOAD_LAT=1, ZERO_REG=31).

1. Reset with reset_n=0 for 2 cycles, then issue src=(3,4) with no writers. Required: forward_sel=(0,0), stall=0, both counters 0.
2. Issue ALU rd=5 with regwrite, then next cycle issue src=(5,5). Required: forward_sel=(1,1). One cycle later with src=(5,0): forward_sel=(2,0).
3. Issue rd=31 with regwrite, then issue src=(31,31). Required: forward_sel=(0,0), stall=0.
4. Issue load rd=7, then issue src=(7,2). Required:
   - cycle 1: stall=1, forward_sel=(0,0);
   - cycle 2, same src held: stall=0, forward_sel=(2,0);
   - stall_count=1.
5. Issue writers rd=9 then rd=9 on consecutive cycles, then src=(9,9). Required: forward_sel=(1,1), the youngest. Then assert flush with a writer rd=9 in entry 0. Next cycle src=9 gives forward_sel=0, because the flushed writer became a bubble at entry 1 and the older rd=9 writer has retired.
6. Hold a forwarding match for 70000 cycles. Required: fwd_count saturates at 65535. Then assert cnt_clear while the match continues: fwd_count=0 the next cycle.

Source files
------------

// File: rtl/forward_tracker.sv
// forward_tracker
// Forwarding and load-use hazard unit that sits beside decode/register-read.
// It tracks in-flight register writers across DEPTH downstream stages.
// Entry 0 is EX. Entry DEPTH-1 is the last stage before writeback.
// For every source operand it produces a forward select and a load-use stall
// request. It also keeps saturating stall and forward performance counters.
//
// Ports
//   clk, reset_n    clock; synchronous active-low reset
//   issue_valid     decode-stage instruction is valid
//   issue_regwrite  decode instruction writes issue_rd
//   issue_is_load   decode instruction is a load
//   issue_rd        decode destination register
//   src_regs        NUM_SRC packed source registers (operand i at i*REG_ADDR_W)
//   flush           squash entry 0 and the current issue
//   cnt_clear       clear both performance counters
//   forward_sel     per operand: 0 = no forward, k = forward from entry k-1
//   stall           hold decode and insert a bubble into entry 0
//   stall_count     saturating count of stall cycles
//   fwd_count       saturating count of unstalled cycles with any forward
module forward_tracker #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ZERO_REG   = 31,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          issue_valid,
    input  logic                          issue_regwrite,
    input  logic                          issue_is_load,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_regs,
    input  logic                          flush,
    input  logic                          cnt_clear,
    output logic [NUM_SRC*SEL_W-1:0]      forward_sel,
    output logic                          stall,
    output logic [15:0]                   stall_count,
    output logic [15:0]                   fwd_count
);

    logic [DEPTH-1:0]                 ent_valid;
    logic [DEPTH-1:0]                 ent_regwrite;
    logic [DEPTH-1:0]                 ent_load;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;

    logic                  any_not_ready;
    logic                  found;
    logic                  not_ready;
    logic [REG_ADDR_W-1:0] src;
    logic [SEL_W-1:0]      sel;
    logic                  any_fwd;

    // The youngest match wins. If that match is a load still too close to
    // the operand, the operand is not ready. An older match must not be
    // used in that case, so the search stops at the first match.
    always_comb begin
        forward_sel   = '0;
        any_not_ready = 1'b0;
        found         = 1'b0;
        not_ready     = 1'b0;
        src           = '0;
        sel           = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src       = src_regs[i*REG_ADDR_W +: REG_ADDR_W];
            found     = 1'b0;
            not_ready = 1'b0;
            sel       = '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!found && ent_valid[k] && ent_regwrite[k] &&
                    ent_rd[k] == src && src != REG_ADDR_W'(ZERO_REG)) begin
                    found = 1'b1;
                    if (ent_load[k] && k < LOAD_LAT) begin
                        not_ready = 1'b1;
                    end else begin
                        sel = SEL_W'(k + 1);
                    end
                end
            end
            forward_sel[i*SEL_W +: SEL_W] = sel;
            any_not_ready = any_not_ready | not_ready;
        end
    end

    assign stall   = issue_valid & any_not_ready;
    assign any_fwd = |forward_sel;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ent_valid    <= '0;
            ent_regwrite <= '0;
            ent_load     <= '0;
            ent_rd       <= '0;
            stall_count  <= '0;
            fwd_count    <= '0;
        end else begin
            // On flush, the instruction leaving entry 0 lands in entry 1 as a bubble.
            for (int unsigned k = 1; k < DEPTH; k++) begin
                ent_valid[k]    <= ent_valid[k-1] & ~(flush && k == 1);
                ent_regwrite[k] <= ent_regwrite[k-1];
                ent_load[k]     <= ent_load[k-1];
                ent_rd[k]       <= ent_rd[k-1];
            end
            ent_valid[0]    <= issue_valid & ~stall & ~flush;
            ent_regwrite[0] <= issue_regwrite;
            ent_load[0]     <= issue_is_load;
            ent_rd[0]       <= issue_rd;

            if (cnt_clear) begin
                stall_count <= '0;
                fwd_count   <= '0;
            end else begin
                if (stall && stall_count != '1) begin
                    stall_count <= stall_count + 16'd1;
                end
                if (any_fwd && !stall && fwd_count != '1) begin
                    fwd_count <= fwd_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_forward_tracker.sv
// tb_forward_tracker
// Directed and randomized bench for forward_tracker with default parameters.
// The reference model keeps a small history ring of accepted instructions.
// Ring slots are indexed by issue cycle. The instruction k+1 cycles old is
// the one the hardware holds in entry k.
module tb_forward_tracker;

    localparam int unsigned RW = 5;
    localparam int unsigned ZR = 31;
    localparam int unsigned NS = 2;
    localparam int unsigned D  = 2;
    localparam int unsigned LL = 1;
    localparam int unsigned SW = $clog2(D + 1);

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 issue_valid;
    logic                 issue_regwrite;
    logic                 issue_is_load;
    logic [RW-1:0]        issue_rd;
    logic [NS*RW-1:0]     src_regs;
    logic                 flush;
    logic                 cnt_clear;
    logic [NS*SW-1:0]     forward_sel;
    logic                 stall;
    logic [15:0]          stall_count;
    logic [15:0]          fwd_count;

    always #5 clk = ~clk;

    forward_tracker #(
        .REG_ADDR_W(RW),
        .ZERO_REG(ZR),
        .NUM_SRC(NS),
        .DEPTH(D),
        .LOAD_LAT(LL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .issue_valid(issue_valid),
        .issue_regwrite(issue_regwrite),
        .issue_is_load(issue_is_load),
        .issue_rd(issue_rd),
        .src_regs(src_regs),
        .flush(flush),
        .cnt_clear(cnt_clear),
        .forward_sel(forward_sel),
        .stall(stall),
        .stall_count(stall_count),
        .fwd_count(fwd_count)
    );

    typedef struct packed {
        logic          v;
        logic          rw;
        logic          ld;
        logic [RW-1:0] rd;
    } rec_t;

    rec_t        hist [8];
    int unsigned cyc = 8;
    int unsigned m_sc = 0;
    int unsigned m_fc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic        chk_on = 1'b0;

    logic [NS*SW-1:0] s_fs;
    logic             s_st;
    logic [15:0]      s_sc;
    logic [15:0]      s_fc;

    function automatic void model_comb(output logic [NS*SW-1:0] fs, output logic st);
        logic [RW-1:0] s;
        rec_t          r;
        bit            nr_any;
        fs     = '0;
        nr_any = 0;
        for (int i = 0; i < NS; i++) begin
            s = src_regs[i*RW +: RW];
            for (int age = 0; age < D; age++) begin
                r = hist[(cyc - 1 - age) % 8];
                if (r.v && r.rw && r.rd == s && s != RW'(ZR)) begin
                    if (r.ld && age < LL) nr_any = 1;
                    else fs[i*SW +: SW] = SW'(age + 1);
                    break;
                end
            end
        end
        st = issue_valid && nr_any;
    endfunction

    function automatic void model_edge(input logic [NS*SW-1:0] fs, input logic st);
        if (!reset_n) begin
            for (int j = 0; j < 8; j++) hist[j] = '0;
            m_sc = 0;
            m_fc = 0;
        end else begin
            if (flush) hist[(cyc - 1) % 8].v = 1'b0;
            hist[cyc % 8] = '{v: issue_valid && !st && !flush, rw: issue_regwrite,
                              ld: issue_is_load, rd: issue_rd};
            if (cnt_clear) begin
                m_sc = 0;
                m_fc = 0;
            end else begin
                if (st && m_sc < 65535) m_sc++;
                if (fs != '0 && !st && m_fc < 65535) m_fc++;
            end
        end
        cyc++;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic ld, input logic [RW-1:0] rd,
                         input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                         input logic fl, input logic clr);
        issue_valid    = v;
        issue_regwrite = rw;
        issue_is_load  = ld;
        issue_rd       = rd;
        src_regs       = {s1, s0};
        flush          = fl;
        cnt_clear      = clr;
    endtask

    // Inputs are set 1 time unit after a rising edge. Outputs are sampled
    // 3 units later, well before the next rising edge.
    task automatic cycle();
        logic [NS*SW-1:0] mfs;
        logic             mst;
        #3;
        model_comb(mfs, mst);
        s_fs = forward_sel;
        s_st = stall;
        s_sc = stall_count;
        s_fc = fwd_count;
        if (chk_on) begin
            check("forward_sel", 32'(s_fs), 32'(mfs));
            check("stall", 32'(s_st), 32'(mst));
            check("stall_count", 32'(s_sc), m_sc);
            check("fwd_count", 32'(s_fc), m_fc);
        end
        @(posedge clk);
        model_edge(mfs, mst);
        #1;
    endtask

    logic [RW-1:0] pool [5];

    initial begin
        pool[0] = 5'd0; pool[1] = 5'd1; pool[2] = 5'd2; pool[3] = 5'd3; pool[4] = 5'd31;
        for (int j = 0; j < 8; j++) hist[j] = '0;
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        cycle();
        cycle();
        reset_n = 1'b1;
        chk_on  = 1'b1;

        // 1: no writers after reset
        drive(1, 0, 0, 0, 3, 4, 0, 0);
        cycle();
        check("rst_fwd", 32'(s_fs), 32'h0);
        check("rst_stall", 32'(s_st), 32'h0);
        check("rst_scnt", 32'(s_sc), 32'h0);
        check("rst_fcnt", 32'(s_fc), 32'h0);

        // 2: ALU forwarding from entry 0, then from entry 1
        drive(1, 1, 0, 5, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 5, 5, 0, 0);
        cycle();
        check("alu_fwd_e0", 32'(s_fs), 32'h5);
        drive(1, 0, 0, 0, 5, 0, 0, 0);
        cycle();
        check("alu_fwd_e1", 32'(s_fs), 32'h2);

        // 3: zero register is never forwarded
        drive(1, 1, 0, 31, 1, 2, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 31, 31, 0, 0);
        cycle();
        check("zero_fwd", 32'(s_fs), 32'h0);
        check("zero_stall", 32'(s_st), 32'h0);

        // 4: load-use stalls once, then forwards from entry 1
        drive(1, 1, 1, 7, 1, 2, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 7, 2, 0, 0);
        cycle();
        check("lu_stall", 32'(s_st), 32'h1);
        check("lu_fwd0", 32'(s_fs), 32'h0);
        cycle();
        check("lu_unstall", 32'(s_st), 32'h0);
        check("lu_fwd1", 32'(s_fs), 32'h2);
        check("lu_scnt", 32'(s_sc), 32'h1);

        // 5: youngest writer shadows the older one; flush turns entry 0 into a bubble
        drive(1, 1, 0, 9, 0, 0, 0, 0);
        cycle();
        cycle();
        drive(1, 1, 0, 9, 9, 9, 0, 0);
        cycle();
        check("shadow_fwd", 32'(s_fs), 32'h5);
        drive(1, 0, 0, 0, 9, 9, 1, 0);
        cycle();
        drive(1, 0, 0, 0, 9, 9, 0, 0);
        cycle();
        check("flush_fwd", 32'(s_fs), 32'h0);

        // randomized traffic with occasional flush, clear and reset
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                  pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3);
            cycle();
        end
        reset_n = 1'b1;

        // 6: fwd_count saturation and clear priority
        drive(1, 1, 0, 5, 5, 5, 0, 1);
        cycle();
        chk_on = 1'b0;
        drive(1, 1, 0, 5, 5, 5, 0, 0);
        for (int n = 0; n < 70000; n++) cycle();
        chk_on = 1'b1;
        cycle();
        check("fcnt_sat", 32'(s_fc), 32'hFFFF);
        drive(1, 1, 0, 5, 5, 5, 0, 1);
        cycle();
        drive(1, 1, 0, 5, 5, 5, 0, 0);
        cycle();
        check("fcnt_clr", 32'(s_fc), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
